// File: rtl/ramb18_port_arbiter_if.sv
// Bundle between the two read / two write requesters, the arbiter, and the shared RAM ports.
// The master side is the requesters and the RAM together: it drives the requests and ram_read_data.
interface ramb18_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
);
  logic                  rd0_valid;
  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic                  rd0_ready;
  logic                  rd0_data_valid;
  logic                  rd1_valid;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic                  rd1_ready;
  logic                  rd1_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr0_valid;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic [DATA_WIDTH-1:0] wr0_data;
  logic                  wr0_ready;
  logic                  wr1_valid;
  logic [ADDR_WIDTH-1:0] wr1_addr;
  logic [DATA_WIDTH-1:0] wr1_data;
  logic                  wr1_ready;

  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic                  ram_write_en;

  modport master (
    output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    output wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    output ram_read_data,
    input  rd0_ready, rd0_data_valid, rd1_ready, rd1_data_valid, rd_data,
    input  wr0_ready, wr1_ready,
    input  ram_read_addr, ram_write_addr, ram_write_data, ram_write_en
  );

  modport slave (
    input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    input  wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    input  ram_read_data,
    output rd0_ready, rd0_data_valid, rd1_ready, rd1_data_valid, rd_data,
    output wr0_ready, wr1_ready,
    output ram_read_addr, ram_write_addr, ram_write_data, ram_write_en
  );
endinterface

// File: rtl/ramb18_port_arbiter.sv
// Round-robin arbiter sharing one RAMB18 read port and one write port between two readers
// and two writers, with same-address read/write collision avoidance and a read starvation guard.
module ramb18_port_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 18,
  parameter int MAX_READ_STALL = 4
) (
  input logic                 clk,
  input logic                 rst,
  ramb18_port_arbiter_if.slave bus
);
  localparam int STALL_W = (MAX_READ_STALL > 0) ? $clog2(MAX_READ_STALL + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_READ_STALL);

  logic                  rd_last;
  logic                  wr_last;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  rd0_dv;
  logic                  rd1_dv;

  logic                  rd_any;
  logic                  wr_any;
  logic                  rd_pick;
  logic                  wr_pick;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  collide;
  logic                  stall_out;
  logic                  rd_go;
  logic                  wr_go;

  always_comb begin
    rd_any    = bus.rd0_valid | bus.rd1_valid;
    wr_any    = bus.wr0_valid | bus.wr1_valid;
    // With both requesting, the one not served last wins; otherwise the lone requester wins.
    rd_pick   = (bus.rd0_valid & bus.rd1_valid) ? ~rd_last : bus.rd1_valid;
    wr_pick   = (bus.wr0_valid & bus.wr1_valid) ? ~wr_last : bus.wr1_valid;
    rd_addr   = rd_pick ? bus.rd1_addr : bus.rd0_addr;
    wr_addr   = wr_pick ? bus.wr1_addr : bus.wr0_addr;
    wr_data   = wr_pick ? bus.wr1_data : bus.wr0_data;
    collide   = rd_any & wr_any & (rd_addr == wr_addr);
    stall_out = (stall_cnt == STALL_LIMIT);
    rd_go     = ~rst & rd_any & (~collide | stall_out);
    wr_go     = ~rst & wr_any & (~collide | ~stall_out);
  end

  always_comb begin
    bus.rd0_ready      = rd_go & ~rd_pick;
    bus.rd1_ready      = rd_go & rd_pick;
    bus.wr0_ready      = wr_go & ~wr_pick;
    bus.wr1_ready      = wr_go & wr_pick;
    bus.ram_read_addr  = rd_go ? rd_addr : '0;
    bus.ram_write_en   = wr_go;
    bus.ram_write_addr = wr_go ? wr_addr : '0;
    bus.ram_write_data = wr_go ? wr_data : '0;
    // Masked by rst so a read granted just before reset never reports data during reset.
    bus.rd0_data_valid = rd0_dv & ~rst;
    bus.rd1_data_valid = rd1_dv & ~rst;
    bus.rd_data        = bus.ram_read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_last   <= 1'b1;
      wr_last   <= 1'b1;
      stall_cnt <= '0;
      rd0_dv    <= 1'b0;
      rd1_dv    <= 1'b0;
    end else begin
      if (rd_go) rd_last <= rd_pick;
      if (wr_go) wr_last <= wr_pick;
      stall_cnt <= (collide && !stall_out) ? stall_cnt + 1'b1 : '0;
      rd0_dv    <= rd_go & ~rd_pick;
      rd1_dv    <= rd_go & rd_pick;
    end
  end
endmodule

// File: tb/tb_ramb18_port_arbiter.sv
// Bench for ramb18_port_arbiter: directed scenarios followed by constrained-random traffic,
// every cycle compared against a transaction-level model of grants, RAM contents and read returns.
module tb_ramb18_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 18;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;

  ramb18_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ramb18_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_READ_STALL(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Block RAM stand-in: one-cycle read latency.
  logic [DW-1:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_write_en) ram[bus.ram_write_addr] <= bus.ram_write_data;
    bus.ram_read_data <= ram[bus.ram_read_addr];
  end

  int checks = 0;
  int passed = 0;

  // Reference model state.
  int            m_rd_last = 1;
  int            m_wr_last = 1;
  int            m_stalls  = 0;
  int            m_pend    = -1;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_mem [int];
  int            last_gr = -1;
  int            last_gw = -1;

  logic obs_rd0r, obs_rd1r, obs_wr0r, obs_wr1r, obs_wen, obs_dv0, obs_dv1;
  logic [AW-1:0] obs_raddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input bit v0, input bit v1, input int last);
    int order[2];
    order = (last == 0) ? '{1, 0} : '{0, 1};
    for (int k = 0; k < 2; k++)
      if ((order[k] == 0 && v0) || (order[k] == 1 && v1)) return order[k];
    return -1;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input int a);
    return m_mem.exists(a) ? m_mem[a] : '0;
  endfunction

  // One clock cycle with the currently driven inputs: check at negedge, advance model after posedge.
  task automatic cycle();
    int rw, ww, gr, gw;
    bit col;
    int ra[2], wa[2];
    logic [DW-1:0] wd[2];
    ra = '{int'(bus.rd0_addr), int'(bus.rd1_addr)};
    wa = '{int'(bus.wr0_addr), int'(bus.wr1_addr)};
    wd = '{bus.wr0_data, bus.wr1_data};
    rw = rr_pick(bus.rd0_valid, bus.rd1_valid, m_rd_last);
    ww = rr_pick(bus.wr0_valid, bus.wr1_valid, m_wr_last);
    col = (rw >= 0) && (ww >= 0) && (ra[rw] == wa[ww]);
    gr = rw;
    gw = ww;
    if (col) begin
      if (m_stalls >= MAXS) gw = -1;
      else gr = -1;
    end
    if (rst) begin
      gr = -1;
      gw = -1;
    end

    @(negedge clk);
    obs_rd0r = bus.rd0_ready;  obs_rd1r = bus.rd1_ready;
    obs_wr0r = bus.wr0_ready;  obs_wr1r = bus.wr1_ready;
    obs_wen  = bus.ram_write_en;
    obs_dv0  = bus.rd0_data_valid;  obs_dv1 = bus.rd1_data_valid;
    obs_raddr = bus.ram_read_addr;
    chk("rd0_ready", obs_rd0r, 32'(gr == 0));
    chk("rd1_ready", obs_rd1r, 32'(gr == 1));
    chk("wr0_ready", obs_wr0r, 32'(gw == 0));
    chk("wr1_ready", obs_wr1r, 32'(gw == 1));
    chk("ram_write_en", obs_wen, 32'(gw >= 0));
    chk("ram_write_addr", bus.ram_write_addr, (gw >= 0) ? wa[gw] : 0);
    chk("ram_write_data", bus.ram_write_data, (gw >= 0) ? 32'(wd[gw]) : 0);
    chk("ram_read_addr", obs_raddr, (gr >= 0) ? ra[gr] : 0);
    chk("rd0_data_valid", obs_dv0, 32'(m_pend == 0 && !rst));
    chk("rd1_data_valid", obs_dv1, 32'(m_pend == 1 && !rst));
    if (m_pend >= 0 && !rst) chk("rd_data", bus.rd_data, 32'(m_pend_data));

    @(posedge clk);
    #1;
    if (rst) begin
      m_rd_last = 1;
      m_wr_last = 1;
      m_stalls  = 0;
      m_pend    = -1;
    end else begin
      m_pend = gr;
      if (gr >= 0) begin
        m_pend_data = mem_rd(ra[gr]);
        m_rd_last   = gr;
      end
      if (gw >= 0) begin
        m_mem[wa[gw]] = wd[gw];
        m_wr_last     = gw;
      end
      m_stalls = (col && gr < 0) ? m_stalls + 1 : 0;
    end
    last_gr = gr;
    last_gw = gw;
  endtask

  task automatic clear();
    bus.rd0_valid = 1'b0;  bus.rd1_valid = 1'b0;
    bus.wr0_valid = 1'b0;  bus.wr1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    bus.rd0_addr = '0;  bus.rd1_addr = '0;
    bus.wr0_addr = '0;  bus.wr1_addr = '0;
    bus.wr0_data = '0;  bus.wr1_data = '0;
    @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    bus.rd0_valid = 1'b1;  bus.wr0_valid = 1'b1;
    bus.rd0_addr = 10'd9;  bus.wr0_addr = 10'd8;
    cycle();
    chk("reset_rd0_ready", obs_rd0r, 0);
    chk("reset_wr_en", obs_wen, 0);
    rst = 1'b0;
    clear();

    // Single write then read back on requester 1.
    bus.wr0_valid = 1'b1;  bus.wr0_addr = 10'd5;  bus.wr0_data = 18'h2A5A5;
    cycle();
    chk("wr_single_ready", obs_wr0r, 1);
    clear();
    bus.rd1_valid = 1'b1;  bus.rd1_addr = 10'd5;
    cycle();
    chk("rd_single_ready", obs_rd1r, 1);
    chk("rd_single_dv1", bus.rd1_data_valid, 1);
    chk("rd_single_dv0", bus.rd0_data_valid, 0);
    chk("rd_single_data", bus.rd_data, 32'h2A5A5);
    clear();

    // Read round-robin from reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.rd0_valid = 1'b1;  bus.rd0_addr = 10'd1;
    bus.rd1_valid = 1'b1;  bus.rd1_addr = 10'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_rd0", obs_rd0r, 32'(i % 2 == 0));
      chk("rr_rd1", obs_rd1r, 32'(i % 2 == 1));
    end
    clear();

    // Write round-robin from reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.wr0_valid = 1'b1;  bus.wr0_addr = 10'd20;  bus.wr0_data = 18'h11111;
    bus.wr1_valid = 1'b1;  bus.wr1_addr = 10'd21;  bus.wr1_data = 18'h22222;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_wr0", obs_wr0r, 32'(i % 2 == 0));
      chk("rr_wr1", obs_wr1r, 32'(i % 2 == 1));
    end
    clear();

    // Non-colliding read and write in the same cycle.
    bus.wr0_valid = 1'b1;  bus.wr0_addr = 10'd10;  bus.wr0_data = 18'h3C3C3;
    bus.rd0_valid = 1'b1;  bus.rd0_addr = 10'd11;
    cycle();
    chk("conc_wr0", obs_wr0r, 1);
    chk("conc_rd0", obs_rd0r, 1);
    chk("conc_wen", obs_wen, 1);
    chk("conc_raddr", obs_raddr, 11);
    clear();

    // Collision: write wins MAXS times, then the stalled read overrides.
    bus.wr0_valid = 1'b1;  bus.wr0_addr = 10'd7;
    bus.rd0_valid = 1'b1;  bus.rd0_addr = 10'd7;
    for (int i = 0; i < MAXS; i++) begin
      bus.wr0_data = 18'(i + 100);
      cycle();
      chk("coll_rd_stalled", obs_rd0r, 0);
      chk("coll_wr_granted", obs_wr0r, 1);
    end
    cycle();
    chk("coll_rd_override", obs_rd0r, 1);
    chk("coll_wr_blocked", obs_wr0r, 0);
    bus.rd0_valid = 1'b0;
    cycle();
    chk("coll_wr_resume", obs_wr0r, 1);
    chk("coll_rd_data", bus.rd0_data_valid, 0);
    clear();

    // Reset right after a read grant suppresses its data_valid.
    bus.rd0_valid = 1'b1;  bus.rd0_addr = 10'd3;
    cycle();
    chk("rst_mid_grant", obs_rd0r, 1);
    clear();
    rst = 1'b1;
    cycle();
    chk("rst_mid_dv0", obs_dv0, 0);
    rst = 1'b0;
    bus.rd0_valid = 1'b1;  bus.rd0_addr = 10'd1;
    bus.rd1_valid = 1'b1;  bus.rd1_addr = 10'd2;
    cycle();
    chk("rst_mid_rd0_first", obs_rd0r, 1);
    chk("rst_mid_rd1_wait", obs_rd1r, 0);
    clear();

    // Idle.
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_wen", obs_wen, 0);
    end

    // Random traffic on a small address range to provoke collisions; held until accepted.
    last_gr = -1;
    last_gw = -1;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!bus.rd0_valid || last_gr == 0) begin
        bus.rd0_valid = 1'($urandom_range(0, 1));
        bus.rd0_addr  = 10'($urandom_range(0, 3));
      end
      if (!bus.rd1_valid || last_gr == 1) begin
        bus.rd1_valid = 1'($urandom_range(0, 1));
        bus.rd1_addr  = 10'($urandom_range(0, 3));
      end
      if (!bus.wr0_valid || last_gw == 0) begin
        bus.wr0_valid = 1'($urandom_range(0, 1));
        bus.wr0_addr  = 10'($urandom_range(0, 3));
        bus.wr0_data  = 18'($urandom);
      end
      if (!bus.wr1_valid || last_gw == 1) begin
        bus.wr1_valid = 1'($urandom_range(0, 1));
        bus.wr1_addr  = 10'($urandom_range(0, 3));
        bus.wr1_data  = 18'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
